// File: rtl/lcd_pkg.sv
// Shared LCD definitions: ASCII constants, decimal converter sizing and the
// converter state enumeration. Also imported by the QC12864 controller.
package lcd_pkg;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

   localparam int DEC_DIGITS = 10;
   localparam int DEC_WIDTH  = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FORMAT = 2'd2
   } dec_state_t;

endpackage : lcd_pkg

// File: rtl/lcd_dec_ascii_if.sv
// Request/result bundle between a value producer and the decimal converter.
// master drives start/bin, slave returns busy/done/ascii.
interface lcd_dec_ascii_if
   import lcd_pkg::*;
#(
   parameter int WIDTH  = DEC_WIDTH,
   parameter int DIGITS = DEC_DIGITS
);

   logic                  start;
   logic [WIDTH-1:0]      bin;
   logic                  busy;
   logic                  done;
   logic [8*DIGITS-1:0]   ascii;

   modport master (output start, output bin, input busy, input done, input ascii);
   modport slave  (input start, input bin, output busy, output done, output ascii);

endinterface : lcd_dec_ascii_if

// File: rtl/lcd_dec_ascii_bcd_add3.sv
// Single BCD digit corrector for the double-dabble step: digits of 5 or more
// get 3 added so the following left shift carries correctly into the next digit.
module bcd_add3 (
   input  logic [3:0] din,
   output logic [3:0] dout
);

   // Correct one digit ahead of the shift.
   always_comb begin
      dout = (din >= 4'd5) ? din + 4'd3 : din;
   end

endmodule : bcd_add3

// File: rtl/lcd_dec_ascii.sv
// 32-bit binary to 10-digit decimal ASCII converter, one bit per clock.
// Optional feature macro: LCD_DEC_LEADING_BLANK_EN (leading zeros shown as
// spaces, units digit always numeric). Results stay stable between conversions.
module lcd_dec_ascii
   import lcd_pkg::*;
#(
   parameter int WIDTH  = DEC_WIDTH,
   parameter int DIGITS = DEC_DIGITS
) (
   input  logic           clk,
   input  logic           rst,
   lcd_dec_ascii_if.slave bus
);

   localparam logic [1:0] S_IDLE   = IDLE;
   localparam logic [1:0] S_SHIFT  = SHIFT;
   localparam logic [1:0] S_FORMAT = FORMAT;

`ifdef LCD_DEC_LEADING_BLANK_EN
   localparam logic [8*DIGITS-1:0] ASCII_RESET = {{(DIGITS-1){ASCII_SPACE}}, ASCII_ZERO};
`else
   localparam logic [8*DIGITS-1:0] ASCII_RESET = {DIGITS{ASCII_ZERO}};
`endif

   logic [1:0]          state_q;
   logic [4*DIGITS-1:0] bcd_q;
   logic [4*DIGITS-1:0] bcd_adj;
   logic [WIDTH-1:0]    sh_q;
   logic [5:0]          cnt_q;
   logic                busy_q;
   logic                done_q;
   logic [8*DIGITS-1:0] ascii_q;
   logic [8*DIGITS-1:0] ascii_fmt;

   // Per-digit add-3 correction, all digits in parallel.
   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .din  (bcd_q[4*g +: 4]),
         .dout (bcd_adj[4*g +: 4])
      );
   end

`ifdef LCD_DEC_LEADING_BLANK_EN
   // Format BCD to ASCII, blanking zeros above the first non-zero digit.
   always_comb begin
      logic       lead;
      logic [3:0] digit;
      // NOTE: every combinational output gets a default before any branch, otherwise a latch is inferred.
      ascii_fmt = '0;
      lead      = 1'b1;
      digit     = '0;
      for (int i = DIGITS-1; i >= 0; i--) begin
         digit = bcd_q[4*i +: 4];
         if (lead && (digit == 4'd0) && (i != 0)) begin
            ascii_fmt[8*i +: 8] = ASCII_SPACE;
         end else begin
            lead                = 1'b0;
            ascii_fmt[8*i +: 8] = ASCII_ZERO + {4'h0, digit};
         end
      end
   end
`else
   // Format BCD to ASCII, keeping leading zeros.
   always_comb begin
      ascii_fmt = '0;
      for (int i = 0; i < DIGITS; i++) begin
         ascii_fmt[8*i +: 8] = ASCII_ZERO + {4'h0, bcd_q[4*i +: 4]};
      end
   end
`endif

   // Conversion sequencer: capture, 32 correct-and-shift steps, then publish.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (rst) begin
         state_q <= S_IDLE;
         bcd_q   <= '0;
         sh_q    <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ascii_q <= ASCII_RESET;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  sh_q    <= bus.bin;
                  bcd_q   <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               bcd_q <= {bcd_adj[4*DIGITS-2:0], sh_q[WIDTH-1]};
               sh_q  <= {sh_q[WIDTH-2:0], 1'b0};
               cnt_q <= cnt_q + 6'd1;
               if (cnt_q == 6'(WIDTH-1)) begin
                  state_q <= S_FORMAT;
               end
            end
            S_FORMAT: begin
               ascii_q <= ascii_fmt;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.ascii = ascii_q;

endmodule : lcd_dec_ascii

// File: tb/tb_lcd_dec_ascii.sv
// Self-checking bench for lcd_dec_ascii: directed cases plus random values,
// compared against a decimal model built from repeated division by ten.
module tb_lcd_dec_ascii;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   lcd_dec_ascii_if bus ();

   lcd_dec_ascii u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Expected ten-byte image for a value, derived from its decimal digits.
   function automatic logic [79:0] model(input logic [31:0] v);
      longint unsigned x = 64'(v);
      int              d[10];
      bit              lead = 1'b1;
      logic [79:0]     r = '0;
      for (int i = 0; i < 10; i++) begin
         d[i] = int'(x % 10);
         x    = x / 10;
      end
      for (int i = 9; i >= 0; i--) begin
`ifdef LCD_DEC_LEADING_BLANK_EN
         if (lead && d[i] == 0 && i != 0) begin
            r[8*i +: 8] = 8'h20;
            continue;
         end
`endif
         lead        = 1'b0;
         r[8*i +: 8] = 8'(48 + d[i]);
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for done after a start edge; returns number of edges waited.
   task automatic wait_done(input bit noisy_start, output int n);
      n = 0;
      do begin
         if (noisy_start) bus.start = 1'($urandom_range(0, 1));
         tick();
         n++;
      end while (!bus.done && n < 80);
      bus.start = 1'b0;
   endtask

   task automatic run_conv(input string tag, input logic [31:0] v, input bit noisy);
      int n;
      bus.bin   = v;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.bin   = $urandom;
      check({tag, "_busy_hi"}, 80'(bus.busy), 80'(1));
      wait_done(noisy, n);
      check({tag, "_latency"}, 80'(n), 80'(33));
      check({tag, "_busy_lo"}, 80'(bus.busy), 80'(0));
      check({tag, "_ascii"}, bus.ascii, model(v));
      tick();
      check({tag, "_done_1cyc"}, 80'(bus.done), 80'(0));
   endtask

   initial begin
      int          n;
      int          done_seen;
      logic [79:0] prev;
      bus.start = 1'b0;
      bus.bin   = '0;

      // Reset state
      rst = 1'b1;
      tick();
      tick();
      check("rst_busy", 80'(bus.busy), 80'(0));
      check("rst_done", 80'(bus.done), 80'(0));
      check("rst_ascii", bus.ascii, model(32'd0));
      rst = 1'b0;
      tick();

      // Directed values
      run_conv("v2294967296", 32'd2294967296, 1'b0);
      run_conv("vmax", 32'hFFFF_FFFF, 1'b0);
      run_conv("vzero", 32'd0, 1'b0);
      run_conv("v1234", 32'd1234, 1'b0);

      // Held start: busy pulses ignored, done-cycle start accepted
      bus.bin   = 32'd5;
      bus.start = 1'b1;
      tick();
      bus.bin = 32'd99;
      prev    = bus.ascii;
      for (int i = 0; i < 16; i++) tick();
      check("held_ascii_stable", bus.ascii, prev);
      n = 16;
      while (!bus.done && n < 80) begin
         tick();
         n++;
      end
      check("held_latency", 80'(n), 80'(33));
      check("held_first", bus.ascii, model(32'd5));
      tick();
      check("held_rearm_busy", 80'(bus.busy), 80'(1));
      bus.start = 1'b0;
      wait_done(1'b0, n);
      check("held_second_latency", 80'(n + 1), 80'(34));
      check("held_second", bus.ascii, model(32'd99));
      tick();

      // Reset in the middle of SHIFT discards the conversion
      run_conv("pre5", 32'd5, 1'b0);
      bus.bin   = 32'd77;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 14; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_busy", 80'(bus.busy), 80'(0));
      check("midrst_done", 80'(bus.done), 80'(0));
      check("midrst_ascii", bus.ascii, model(32'd0));
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.done) done_seen++;
      end
      check("midrst_no_done", 80'(done_seen), 80'(0));
      check("midrst_ascii_hold", bus.ascii, model(32'd0));
      run_conv("after_rst", 32'd77, 1'b0);

      // Random values, with start noise while busy
      for (int i = 0; i < 20; i++) begin
         logic [31:0] v;
         v = (i % 4 == 0) ? 32'($urandom_range(0, 999)) : $urandom;
         run_conv($sformatf("rand%0d", i), v, 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_lcd_dec_ascii
